// File: rtl/ov7670_cfg_pkg.sv
// Shared types and table-entry encodings for the OV7670 register-table sequencer.
package ov7670_cfg_pkg;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_DELAY    = 3'd4,
    S_DONE     = 3'd5,
    S_ERROR    = 3'd6
  } state_e;

  localparam logic [15:0] ENTRY_END = 16'hFFFF;
  localparam logic [7:0]  DELAY_TAG = 8'hF0;

  // 16'hF0nn: wait nn milliseconds
  function automatic logic is_delay(input logic [15:0] entry);
    return entry[15:8] == DELAY_TAG;
  endfunction

endpackage

// File: rtl/cfg_ms_tick.sv
// Free-running millisecond strobe; restarting it with clear gives a full first interval.
module cfg_ms_tick #(
  parameter int CLK_HZ = 25000000
) (
  input  logic clk25_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int PERIOD = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (clear_i || tick_o) cnt_d = RELOAD;
  end

  always_ff @(posedge clk25_i) begin
    if (rst_i) cnt_q <= RELOAD;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// Walks the camera register table in ROM, issuing writes to the SCCB engine with
// millisecond delays, NACK retries and done/error reporting.
//   state    | meaning
//   FETCH    | present index on rom_addr
//   DECODE   | classify rom_data: end / delay / write
//   ISSUE    | cmd_valid high until accepted
//   WAIT_ACK | wait for wr_done, retry on NACK
//   DELAY    | count down ms_count on ms ticks
//   DONE     | table complete, hold
//   ERROR    | retries exhausted, hold
module ov7670_cfg_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter int CLK_HZ    = 25000000,
  parameter int ADDR_W    = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk25_i,
  input  logic              rst_i,
  input  logic              resend_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [7:0]        cmd_reg_o,
  output logic [7:0]        cmd_val_o,
  input  logic              wr_done_i,
  input  logic              wr_nack_i,
  output logic              config_done_o,
  output logic              config_err_o,
  output logic [ADDR_W-1:0] lut_index_o
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [7:0]        ms_q, ms_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        val_q, val_d;
  logic              stale_q, stale_d;
  logic              advance, done_eff, tick, tick_clr;

  // a completion owed to a write abandoned by resend is swallowed here
  assign done_eff = wr_done_i & ~stale_q;
  assign tick_clr = (state_q == S_DECODE) && is_delay(rom_data_i);

  cfg_ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
    .clk25_i (clk25_i),
    .rst_i   (rst_i),
    .clear_i (tick_clr),
    .tick_o  (tick)
  );

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    retry_d = retry_q;
    ms_d    = ms_q;
    reg_d   = reg_q;
    val_d   = val_q;
    stale_d = stale_q & ~wr_done_i;
    advance = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data_i == ENTRY_END) begin
          state_d = S_DONE;
        end else if (is_delay(rom_data_i)) begin
          if (rom_data_i[7:0] == 8'd0) begin
            advance = 1'b1;
          end else begin
            ms_d    = rom_data_i[7:0];
            state_d = S_DELAY;
          end
        end else begin
          reg_d   = rom_data_i[15:8];
          val_d   = rom_data_i[7:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (cmd_ready_i) state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (done_eff) begin
          if (!wr_nack_i) begin
            retry_d = '0;
            advance = 1'b1;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_DELAY: begin
        if (ms_q == 8'd0) advance = 1'b1;
        else if (tick)    ms_d = ms_q - 8'd1;
      end
      default: ;
    endcase
    // an unterminated table that runs off the end counts as complete
    if (advance) begin
      if (&index_q) begin
        state_d = S_DONE;
      end else begin
        index_d = index_q + 1'b1;
        state_d = S_FETCH;
      end
    end
    if (resend_i) begin
      state_d = S_FETCH;
      index_d = '0;
      retry_d = '0;
      ms_d    = '0;
      stale_d = ((state_q == S_WAIT_ACK) && !done_eff) ||
                ((state_q == S_ISSUE) && cmd_ready_i) ||
                (stale_q && !wr_done_i);
    end
  end

  always_ff @(posedge clk25_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      index_q <= '0;
      retry_q <= '0;
      ms_q    <= '0;
      reg_q   <= '0;
      val_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      retry_q <= retry_d;
      ms_q    <= ms_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
      stale_q <= stale_d;
    end
  end

  assign rom_addr_o    = index_q;
  assign lut_index_o   = index_q;
  assign cmd_valid_o   = (state_q == S_ISSUE);
  assign cmd_reg_o     = reg_q;
  assign cmd_val_o     = val_q;
  assign config_done_o = (state_q == S_DONE);
  assign config_err_o  = (state_q == S_ERROR);

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Scoreboard bench: expected writes are queued by the stimulus and checked by a monitor
// on every command handshake; an SCCB model answers each accepted write 20 cycles later.
module tb_ov7670_cfg_sequencer;

  localparam int CLK_HZ = 100000;
  localparam int MS     = CLK_HZ / 1000;

  logic        clk = 1'b0;
  logic        rst, resend, cmd_valid, cmd_ready, wr_done, wr_nack;
  logic        config_done, config_err;
  logic [7:0]  rom_addr, lut_index, cmd_reg, cmd_val;
  logic [15:0] rom_data;
  logic [15:0] rom [0:255];

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];
  bit          nack_plan[$];
  int          acc_cyc[$];
  int          accepts = 0;
  int          cyc = 0;
  int          hold_cycles = 0;
  int          hold_bad = 0;
  int          holds_done = 0;
  int          base, qb, vcnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) rom_data <= rom[rom_addr];

  ov7670_cfg_sequencer #(.CLK_HZ(CLK_HZ), .ADDR_W(8), .MAX_RETRY(3)) dut (
    .clk25_i       (clk),
    .rst_i         (rst),
    .resend_i      (resend),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .cmd_valid_o   (cmd_valid),
    .cmd_ready_i   (cmd_ready),
    .cmd_reg_o     (cmd_reg),
    .cmd_val_o     (cmd_val),
    .wr_done_i     (wr_done),
    .wr_nack_i     (wr_nack),
    .config_done_o (config_done),
    .config_err_o  (config_err),
    .lut_index_o   (lut_index)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  // Monitor: every handshake pops one expected {reg,val}
  always begin
    @(negedge clk);
    #1;
    if (cmd_valid && cmd_ready) begin
      accepts++;
      acc_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL write_unexpected: got %02h%02h expected none", cmd_reg, cmd_val);
      end else begin
        chk("write_order", {cmd_reg, cmd_val}, exp_q.pop_front());
      end
    end
  end

  // SCCB responder: wr_done 20 cycles after each accept, NACK per plan
  initial begin
    bit n_sel;
    wr_done = 1'b0;
    wr_nack = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (cmd_valid && cmd_ready) begin
        n_sel = (nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
        fork
          automatic bit nn = n_sel;
          begin
            repeat (20) @(negedge clk);
            wr_nack = nn;
            wr_done = 1'b1;
            @(negedge clk);
            wr_done = 1'b0;
            wr_nack = 1'b0;
          end
        join_none
      end
    end
  end

  // cmd_ready is high unless a hold is armed, then low while watching for stability
  initial begin
    logic [7:0] cap_reg, cap_val;
    cmd_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_valid && hold_cycles > 0) begin
        cap_reg   = cmd_reg;
        cap_val   = cmd_val;
        cmd_ready = 1'b0;
        for (int i = 0; i < hold_cycles; i++) begin
          @(negedge clk);
          if (!cmd_valid || cmd_reg != cap_reg || cmd_val != cap_val) hold_bad++;
        end
        hold_cycles = 0;
        holds_done++;
        cmd_ready   = 1'b1;
      end
    end
  end

  task automatic load4(input logic [15:0] a, b, c, d);
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic wait_end(input string name, input int budget);
    int k = 0;
    while (!config_done && !config_err && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!config_done && !config_err) begin
      n_checks++;
      $display("FAIL %s: got no done/err expected one within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_acc(input string name, input int target, input int budget);
    int k = 0;
    while (accepts < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (accepts < target) begin
      n_checks++;
      $display("FAIL %s: got %0d writes expected %0d", name, accepts, target);
    end
  endtask

  task automatic pulse_resend();
    resend = 1'b1;
    @(negedge clk);
    resend = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    resend = 1'b0;
    load4(16'h1280, 16'hF00A, 16'h1100, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_done", config_done, 0);
    chk("rst_err", config_err, 0);
    chk("rst_lut", lut_index, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_cmd", {cmd_reg, cmd_val}, 0);

    // two writes separated by a 10 ms delay entry
    base = accepts; qb = acc_cyc.size();
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1100);
    rst = 1'b0;
    wait_end("t1_timeout", 3000);
    chk("t1_done", config_done, 1);
    chk("t1_err", config_err, 0);
    chk("t1_lut", lut_index, 3);
    chk("t1_writes", accepts - base, 2);
    if (acc_cyc.size() >= qb + 2) chk_range("t1_gap", acc_cyc[qb+1] - acc_cyc[qb], 10*MS - 30, 10*MS + 30);
    else chk("t1_gap_samples", acc_cyc.size() - qb, 2);

    // ready withheld 50 cycles
    apply_reset();
    load4(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    base = accepts; hold_cycles = 50;
    exp_q.push_back(16'h1280);
    rst = 1'b0;
    wait_end("t2_timeout", 500);
    chk("t2_held", holds_done, 1);
    chk("t2_stable", hold_bad, 0);
    chk("t2_writes", accepts - base, 1);
    chk("t2_done", config_done, 1);

    // two NACKs on entry 0, then ACK
    apply_reset();
    load4(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
    base = accepts;
    nack_plan = '{1'b1, 1'b1};
    repeat (3) exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1100);
    rst = 1'b0;
    wait_end("t3_timeout", 500);
    chk("t3_done", config_done, 1);
    chk("t3_err", config_err, 0);
    chk("t3_lut", lut_index, 2);
    chk("t3_writes", accepts - base, 4);

    // entry 1 NACKed on every attempt
    apply_reset();
    base = accepts;
    nack_plan = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_q.push_back(16'h1280);
    repeat (4) exp_q.push_back(16'h1100);
    rst = 1'b0;
    wait_end("t4_timeout", 500);
    chk("t4_err", config_err, 1);
    chk("t4_done", config_done, 0);
    chk("t4_lut", lut_index, 1);
    chk("t4_writes", accepts - base, 5);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (cmd_valid) vcnt++;
    end
    chk("t4_valid_idle", vcnt, 0);

    // resend out of ERROR
    base = accepts;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1100);
    pulse_resend();
    chk("t5_err_clr", config_err, 0);
    chk("t5_lut0", lut_index, 0);
    wait_end("t5_timeout", 500);
    chk("t5_done", config_done, 1);
    chk("t5_writes", accepts - base, 2);

    // resend while entry 2 awaits its (NACK) completion
    apply_reset();
    load4(16'h1280, 16'h1100, 16'h13E7, 16'hFFFF);
    base = accepts;
    nack_plan = '{1'b0, 1'b0, 1'b1};
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1100); exp_q.push_back(16'h13E7);
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1100); exp_q.push_back(16'h13E7);
    rst = 1'b0;
    wait_acc("t6_acc_timeout", base + 3, 500);
    repeat (5) @(negedge clk);
    pulse_resend();
    chk("t6_lut0", lut_index, 0);
    chk("t6_valid", cmd_valid, 0);
    wait_end("t6_timeout", 1000);
    chk("t6_done", config_done, 1);
    chk("t6_err", config_err, 0);
    chk("t6_lut", lut_index, 3);
    chk("t6_writes", accepts - base, 6);

    // resend out of DONE
    base = accepts;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1100); exp_q.push_back(16'h13E7);
    pulse_resend();
    chk("t7_done_clr", config_done, 0);
    wait_end("t7_timeout", 500);
    chk("t7_done", config_done, 1);
    chk("t7_writes", accepts - base, 3);

    // rst in the middle of a delay entry
    apply_reset();
    load4(16'h1280, 16'hF00A, 16'h1100, 16'hFFFF);
    base = accepts;
    exp_q.push_back(16'h1280);
    rst = 1'b0;
    wait_acc("t8_acc_timeout", base + 1, 200);
    repeat (100) @(negedge clk);
    chk("t8_in_delay_lut", lut_index, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t8_rst_valid", cmd_valid, 0);
    chk("t8_rst_flags", {config_done, config_err}, 0);
    chk("t8_rst_lut", lut_index, 0);
    chk("t8_rst_addr", rom_addr, 0);
    chk("t8_rst_cmd", {cmd_reg, cmd_val}, 0);
    base = accepts;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1100);
    rst = 1'b0;
    wait_end("t8_timeout", 3000);
    chk("t8_done", config_done, 1);
    chk("t8_writes", accepts - base, 2);

    chk("final_pending", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
